// File: rtl/queue_pkg.sv
// queue_pkg: shared widths, limits and the per-cycle event-resolution type
// for the bank-queue occupancy counter (queue_counter).
//
// Contents:
//   PCOUNT_W, TCOUNT_W, INDEX_W : field widths of the ROM index {tcount, pcount}
//   PCOUNT_MAX                  : saturation point of the person count
//   evt_res_e                   : what one cycle of entry/exit events does to the count
//   resolve_event()             : maps (entry event, exit event, count) to evt_res_e
package queue_pkg;

  localparam int PCOUNT_W = 3;
  localparam int TCOUNT_W = 2;
  localparam int INDEX_W  = 5;
  localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = 3'd7;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    DEC,
    DROP_IN,
    DROP_OUT
  } evt_res_e;

  // Simultaneous entry and exit cancel out, even at full or empty, so they
  // never raise an overflow/underflow pulse.
  function automatic evt_res_e resolve_event(input logic in_evt,
                                             input logic out_evt,
                                             input logic [PCOUNT_W-1:0] count);
    if (in_evt && !out_evt)
      return (count == PCOUNT_MAX) ? DROP_IN : INC;
    if (out_evt && !in_evt)
      return (count == '0) ? DROP_OUT : DEC;
    return HOLD;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: conditions one asynchronous photocell level into a
// single-cycle event per low->high transition.
//
// Path: SYNC_STAGES-deep synchronizer -> optional stability filter
// (compiled in with QUEUE_DEBOUNCE_EN) -> rising-edge detector.
//
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset, clears all history
//   sensor : asynchronous sensor level (high while beam broken)
//   evt    : one-cycle pulse on each rising edge of the conditioned level
//
// Macro QUEUE_DEBOUNCE_EN: when defined, the conditioned level only follows
// the synchronized level after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic evt
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("sensor_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  // sync_reg[0] is the first flop after the asynchronous input.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic sync_last;
  logic level;
  logic level_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], sensor};
  end

  assign sync_last = sync_reg[SYNC_STAGES-1];

`ifdef QUEUE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stable_cnt_reg;
  logic             filt_reg;

  // Counts consecutive samples that disagree with the filtered level; any
  // agreeing sample restarts the count, so short glitches never propagate.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_reg       <= 1'b0;
      stable_cnt_reg <= '0;
    end else if (sync_last == filt_reg) begin
      stable_cnt_reg <= '0;
    end else if (stable_cnt_reg == CNT_LAST) begin
      filt_reg       <= sync_last;
      stable_cnt_reg <= '0;
    end else begin
      stable_cnt_reg <= stable_cnt_reg + CNT_W'(1);
    end
  end

  assign level = filt_reg;
`else
  assign level = sync_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) level_prev_reg <= 1'b0;
    else     level_prev_reg <= level;
  end

  // Built only from registers, so no input reaches evt combinationally.
  assign evt = level & ~level_prev_reg;

endmodule

// File: rtl/queue_counter.sv
// queue_counter: bank-queue occupancy tracker feeding the waiting-time ROM.
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   photo_in   : entry sensor (asynchronous)
//   photo_out  : exit sensor (asynchronous)
//   Tcount     : number of open tellers, registered without validation
//   Pcount     : saturating person count 0..7
//   index_rom  : {registered Tcount, Pcount}, ROM address
//   full/empty : Pcount == 7 / Pcount == 0
//   overflow   : one-cycle pulse when an entry is dropped at full
//   underflow  : one-cycle pulse when an exit is dropped at empty
//
// Macro QUEUE_DEBOUNCE_EN enables the per-sensor debounce filter.
module queue_counter
  import queue_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                photo_in,
  input  logic                photo_out,
  input  logic [TCOUNT_W-1:0] Tcount,
  output logic [PCOUNT_W-1:0] Pcount,
  output logic [INDEX_W-1:0]  index_rom,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                underflow
);

  // Bit 0 is the entry sensor, bit 1 the exit sensor.
  logic [1:0] sensor_vec;
  logic [1:0] evt_vec;

  assign sensor_vec = {photo_out, photo_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
    sensor_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sensor (
      .clk   (clk),
      .rst   (rst),
      .sensor(sensor_vec[gi]),
      .evt   (evt_vec[gi])
    );
  end

  logic [PCOUNT_W-1:0] pcount_reg, pcount_next;
  logic [TCOUNT_W-1:0] tcount_reg;
  logic                overflow_reg, overflow_next;
  logic                underflow_reg, underflow_next;
  evt_res_e            res;

  always_comb begin
    pcount_next    = pcount_reg;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    res            = resolve_event(evt_vec[0], evt_vec[1], pcount_reg);
    unique case (res)
      INC:      pcount_next    = pcount_reg + 3'd1;
      DEC:      pcount_next    = pcount_reg - 3'd1;
      DROP_IN:  overflow_next  = 1'b1;
      DROP_OUT: underflow_next = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcount_reg    <= '0;
      tcount_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      pcount_reg    <= pcount_next;
      tcount_reg    <= Tcount;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign Pcount    = pcount_reg;
  assign index_rom = {tcount_reg, pcount_reg};
  assign full      = (pcount_reg == PCOUNT_MAX);
  assign empty     = (pcount_reg == '0);
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
